// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issues one divide at a time to an iterative divider,
// holds operands stable while the divider works, and presents the result
// to writeback with a valid/ready handshake. A watchdog aborts ops the
// divider never completes; flush kills an op in flight.
// Optional feature: define DIV_RESULT_CACHE_EN to keep the last completed
// result and answer a repeated request without using the divider.
module div_issue_ctrl #(
  parameter int unsigned WDOG_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        busy,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_dz,
  output logic        res_timeout,
  output logic        div_valid_in,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_sign,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_valid_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int WD_W = ($clog2(WDOG_CYCLES) < 1) ? 1 : $clog2(WDOG_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

  // Quotient for DIV/DIVU, remainder for MOD/MODU; a zero divisor bypasses
  // whatever the divider returned.
  function automatic logic [31:0] sel_result(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [31:0] q,
                                             input logic [31:0] r);
    logic [31:0] res;
    if (b == 32'd0) begin
      res = op[1] ? a : 32'hFFFF_FFFF;
    end else begin
      res = op[1] ? r : q;
    end
    return res;
  endfunction

  logic [1:0]      state_r;
  logic [1:0]      next_state_s;
  logic [1:0]      op_r;
  logic [31:0]     a_r;
  logic [31:0]     b_r;
  logic            sign_r;
  logic            start_r;
  logic [WD_W-1:0] wdog_r;
  logic [31:0]     res_data_r;
  logic            res_dz_r;
  logic            res_timeout_r;
  logic            accept_s;
  logic            complete_s;
  logic            timeout_s;
  logic            wd_expire_s;
  logic            hit_s;

`ifdef DIV_RESULT_CACHE_EN
  logic        cache_vld_r;
  logic        cache_sign_r;
  logic [31:0] cache_a_r;
  logic [31:0] cache_b_r;
  logic [31:0] cache_q_r;
  logic [31:0] cache_r_r;

  assign hit_s = cache_vld_r && (cache_sign_r == ~req_op[0]) &&
                 (cache_a_r == req_a) && (cache_b_r == req_b);

  // Remember the last divider-completed op; any flush forgets it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_vld_r  <= 1'b0;
      cache_sign_r <= 1'b0;
      cache_a_r    <= 32'd0;
      cache_b_r    <= 32'd0;
      cache_q_r    <= 32'd0;
      cache_r_r    <= 32'd0;
    end else if (flush) begin
      cache_vld_r <= 1'b0;
    end else if (complete_s) begin
      cache_vld_r  <= 1'b1;
      cache_sign_r <= sign_r;
      cache_a_r    <= a_r;
      cache_b_r    <= b_r;
      cache_q_r    <= div_q;
      cache_r_r    <= div_r;
    end
  end
`else
  assign hit_s = 1'b0;
`endif

  assign wd_expire_s = (wdog_r == WD_LAST);

  // Next-state decode and the one-cycle events that steer the datapath.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    complete_s   = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req_valid && !flush) begin
          accept_s     = 1'b1;
          next_state_s = hit_s ? S_DONE : S_WAIT;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (flush) begin
          // A completion arriving with the flush is already consumed.
          next_state_s = div_valid_out ? S_IDLE : S_DRAIN;
        end else if (div_valid_out) begin
          complete_s   = 1'b1;
          next_state_s = S_DONE;
        end else if (wd_expire_s) begin
          timeout_s    = 1'b1;
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_WAIT;
        end
      end
      S_DONE: begin
        if (flush || res_ready) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_DONE;
        end
      end
      S_DRAIN: begin
        if (div_valid_out || wd_expire_s) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_DRAIN;
        end
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // State, operand holding registers, watchdog and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= S_IDLE;
      op_r          <= 2'd0;
      a_r           <= 32'd0;
      b_r           <= 32'd0;
      sign_r        <= 1'b0;
      start_r       <= 1'b0;
      wdog_r        <= '0;
      res_data_r    <= 32'd0;
      res_dz_r      <= 1'b0;
      res_timeout_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      start_r <= accept_s && !hit_s;
      if (accept_s) begin
        op_r   <= req_op;
        a_r    <= req_a;
        b_r    <= req_b;
        sign_r <= ~req_op[0];
      end
      if ((next_state_s != state_r) &&
          ((next_state_s == S_WAIT) || (next_state_s == S_DRAIN))) begin
        wdog_r <= '0;
      end else if ((state_r == S_WAIT) || (state_r == S_DRAIN)) begin
        wdog_r <= wdog_r + WD_W'(1);
      end else begin
        wdog_r <= '0;
      end
      if (complete_s) begin
        res_data_r    <= sel_result(op_r, a_r, b_r, div_q, div_r);
        res_dz_r      <= (b_r == 32'd0);
        res_timeout_r <= 1'b0;
      end else if (timeout_s) begin
        res_data_r    <= 32'd0;
        res_dz_r      <= 1'b0;
        res_timeout_r <= 1'b1;
`ifdef DIV_RESULT_CACHE_EN
      end else if (accept_s && hit_s) begin
        res_data_r    <= sel_result(req_op, req_a, req_b, cache_q_r, cache_r_r);
        res_dz_r      <= (req_b == 32'd0);
        res_timeout_r <= 1'b0;
`endif
      end else if ((state_r == S_DONE) && (next_state_s == S_IDLE)) begin
        res_data_r    <= 32'd0;
        res_dz_r      <= 1'b0;
        res_timeout_r <= 1'b0;
      end else begin
        res_data_r    <= res_data_r;
        res_dz_r      <= res_dz_r;
        res_timeout_r <= res_timeout_r;
      end
    end
  end

  assign busy         = (state_r == S_WAIT) || (state_r == S_DRAIN) ||
                        ((state_r == S_DONE) && !res_ready);
  assign res_valid    = (state_r == S_DONE);
  assign res_data     = res_data_r;
  assign res_dz       = res_dz_r;
  assign res_timeout  = res_timeout_r;
  assign div_valid_in = start_r;
  assign div_a        = a_r;
  assign div_b        = b_r;
  assign div_sign     = sign_r;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural divider with configurable latency,
// expected results queued at request time and compared when res_valid rises.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_dz;
  logic        res_timeout;
  logic        div_valid_in;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_sign;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        div_valid_out;

  typedef struct packed {
    logic [31:0] d;
    logic        dz;
    logic        to;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   rv_cnt = 0;
  int   pulse_cnt = 0;
  logic rv_prev = 1'b0;
  int   div_lat = 3;
  logic div_respond = 1'b1;
  int   cnt;
  logic [31:0] cap_a;
  logic [31:0] cap_b;
  logic        cap_s;

  div_issue_ctrl #(.WDOG_CYCLES(15)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .flush(flush), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_dz(res_dz), .res_timeout(res_timeout), .div_valid_in(div_valid_in),
    .div_a(div_a), .div_b(div_b), .div_sign(div_sign), .div_q(div_q),
    .div_r(div_r), .div_valid_out(div_valid_out)
  );

  always #5 clk = ~clk;

  // Divider model: latches start, reads operands only when it finishes.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 0; div_valid_out <= 1'b0; div_q <= 32'd0; div_r <= 32'd0;
      cap_a <= 32'd0; cap_b <= 32'd0; cap_s <= 1'b0;
    end else begin
      div_valid_out <= 1'b0;
      if (div_valid_in) begin
        cnt <= div_lat; cap_a <= div_a; cap_b <= div_b; cap_s <= div_sign;
      end else if (cnt == 1) begin
        cnt <= 0;
        if (div_respond) begin
          div_valid_out <= 1'b1;
          if (div_b == 32'd0) begin
            div_q <= 32'hDEAD_BEEF; div_r <= 32'h0BAD_F00D;
          end else if (div_sign) begin
            div_q <= $signed(div_a) / $signed(div_b);
            div_r <= $signed(div_a) % $signed(div_b);
          end else begin
            div_q <= div_a / div_b;
            div_r <= div_a % div_b;
          end
        end
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
      end
    end
  end

  // Count start pulses issued to the divider.
  always @(posedge clk) begin
    if (div_valid_in) pulse_cnt <= pulse_cnt + 1;
  end

  // Scoreboard compare on each new result, operand stability at completion.
  always @(negedge clk) begin
    exp_t e;
    if (res_valid && !rv_prev) begin
      rv_cnt++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_res_valid got data=%h dz=%b to=%b, none expected",
                 res_data, res_dz, res_timeout);
      end else begin
        e = sb_q.pop_front();
        if ({res_data, res_dz, res_timeout} !== {e.d, e.dz, e.to}) begin
          errors++;
          $display("FAIL result got data=%h dz=%b to=%b expected data=%h dz=%b to=%b",
                   res_data, res_dz, res_timeout, e.d, e.dz, e.to);
        end
      end
    end
    rv_prev = res_valid;
    if (rst && div_valid_out) begin
      checks++;
      if ({div_a, div_b, div_sign} !== {cap_a, cap_b, cap_s}) begin
        errors++;
        $display("FAIL operand_stable got a=%h b=%h s=%b expected a=%h b=%h s=%b",
                 div_a, div_b, div_sign, cap_a, cap_b, cap_s);
      end
    end
  end

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] v;
    if (b == 32'd0) v = op[1] ? a : 32'hFFFF_FFFF;
    else begin
      case (op)
        2'd0:    v = $signed(a) / $signed(b);
        2'd1:    v = a / b;
        2'd2:    v = $signed(a) % $signed(b);
        default: v = a % b;
      endcase
    end
    return v;
  endfunction

  // Issue one request, queue its expectation, wait for res_valid.
  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input logic exp_dz, input logic exp_to,
                        output int lat);
    exp_t e;
    e.d = exp_d; e.dz = exp_dz; e.to = exp_to;
    sb_q.push_back(e);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!res_valid) begin
      checks++; errors++;
      $display("FAIL res_wait got no res_valid within 40 cycles, expected one");
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_a = 32'd0; req_b = 32'd0;
    flush = 1'b0; res_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, res_valid, res_dz, res_timeout, div_valid_in, div_sign} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b expected 000000",
               {busy, res_valid, res_dz, res_timeout, div_valid_in, div_sign});
    end
    checks++;
    if ({res_data, div_a, div_b} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h expected zeros", res_data, div_a, div_b);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu;
    int lat;
    int p0;
    p0 = pulse_cnt;
    do_req(2'd1, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, lat);
    checks++;
    if (pulse_cnt - p0 !== 1) begin
      errors++; $display("FAIL divu_pulses got %0d expected 1", pulse_cnt - p0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL divu_busy_after got %b expected 0", busy);
    end
  endtask

  task automatic test_cache;
    int lat;
    int p0;
    p0 = pulse_cnt;
    do_req(2'd1, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, lat);
`ifdef DIV_RESULT_CACHE_EN
    checks++;
    if (pulse_cnt - p0 !== 0 || lat !== 1) begin
      errors++;
      $display("FAIL cache_hit got pulses=%0d lat=%0d expected pulses=0 lat=1",
               pulse_cnt - p0, lat);
    end
`else
    checks++;
    if (pulse_cnt - p0 !== 1) begin
      errors++; $display("FAIL repeat_pulses got %0d expected 1", pulse_cnt - p0);
    end
`endif
  endtask

  task automatic test_signed;
    int lat;
    do_req(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, lat);
    do_req(2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0, lat);
    do_req(2'd3, 32'hFFFF_FFF9, 32'd2, 32'd1, 1'b0, 1'b0, lat);
  endtask

  task automatic test_divzero;
    int lat;
    do_req(2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, lat);
    do_req(2'd3, 32'd5, 32'd0, 32'd5, 1'b1, 1'b0, lat);
  endtask

  task automatic test_backpressure;
    int lat;
    res_ready = 1'b0;
    do_req(2'd1, 32'd81, 32'd9, 32'd9, 1'b0, 1'b0, lat);
    repeat (3) begin
      checks++;
      if ({res_valid, busy, res_data} !== {1'b1, 1'b1, 32'd9}) begin
        errors++;
        $display("FAIL hold_done got v=%b busy=%b data=%h expected 1 1 00000009",
                 res_valid, busy, res_data);
      end
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL release_done got res_valid=%b expected 0", res_valid);
    end
  endtask

  task automatic test_flush;
    int   n;
    int   rv0;
    int   p0;
    exp_t e;
    div_lat = 6;
    rv0 = rv_cnt;
    req_valid = 1'b1; req_op = 2'd1; req_a = 32'd50; req_b = 32'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL drain_busy got %b expected 1", busy);
    end
    e.d = 32'd5; e.dz = 1'b0; e.to = 1'b0;
    sb_q.push_back(e);
    req_valid = 1'b1; req_op = 2'd1; req_a = 32'd20; req_b = 32'd4;
    p0 = pulse_cnt;
    n = 0;
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0 || pulse_cnt !== p0) begin
      errors++;
      $display("FAIL drain_exit got busy=%b new_pulses=%0d expected busy=0 pulses=0",
               busy, pulse_cnt - p0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (div_valid_in !== 1'b1) begin
      errors++; $display("FAIL accept_after_drain got %b expected 1", div_valid_in);
    end
    n = 0;
    while (!res_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (rv_cnt - rv0 !== 1) begin
      errors++; $display("FAIL flush_results got %0d expected 1", rv_cnt - rv0);
    end
    div_lat = 3;
  endtask

  task automatic test_timeout;
    int lat;
    div_respond = 1'b0;
    do_req(2'd0, 32'd9, 32'd3, 32'd0, 1'b0, 1'b1, lat);
    checks++;
    if (lat !== 16) begin
      errors++; $display("FAIL timeout_latency got %0d expected 16", lat);
    end
    div_respond = 1'b1;
  endtask

  task automatic test_reset_mid;
    int rv0;
    rv0 = rv_cnt;
    req_valid = 1'b1; req_op = 2'd0; req_a = 32'd77; req_b = 32'd5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, res_valid, div_valid_in, div_sign, div_a} !== 36'd0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b v=%b dvi=%b s=%b a=%h expected zeros",
               busy, res_valid, div_valid_in, div_sign, div_a);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (rv_cnt !== rv0) begin
      errors++; $display("FAIL mid_reset_result got %0d results expected 0", rv_cnt - rv0);
    end
  endtask

  task automatic test_random;
    int          lat;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i == 5) ? 32'd0 : 32'($urandom_range(1, 1000));
      if (i[0]) b = -b;
      do_req(op, a, b, ref_res(op, a, b), (b == 32'd0), 1'b0, lat);
    end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_cache();
    test_signed();
    test_divzero();
    test_backpressure();
    test_flush();
    test_timeout();
    test_random();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover got %0d entries expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 SHALL have parameter: WDOG_CYCLES, 15, max cycles to wait for div_valid_out before abort.
REQ-002 SHALL have ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  pipeline divide request.
- req_op  in  2  0=DIV signed, 1=DIVU, 2=MOD signed, 3=MODU.
- req_a  in  32  dividend.
- req_b  in  32  divisor.
- flush  in  1  kill in-flight op.
- busy  out  1  stall to pipeline.
- res_valid  out  1  result available.
- res_ready  in  1  writeback accepts result.
- res_data  out  32  quotient or remainder.
- res_dz  out  1  divisor was zero.
- res_timeout  out  1  watchdog abort.
- div_valid_in  out  1  start pulse to divider.
- div_a  out  32  dividend to divider.
- div_b  out  32  divisor to divider.
- div_sign  out  1  signed select to divider.
- div_q  in  32  divider quotient.
- div_r  in  32  divider remainder.
- div_valid_out  in  1  divider done pulse (one cycle).

Function
REQ-003 SHALL implement FSM states IDLE, WAIT, DONE, DRAIN.
REQ-004 IDLE: req_valid=1 and flush=0 captures op/a/b into holding registers, goes to WAIT, and drives div_valid_in=1 for exactly the first WAIT cycle.
REQ-005 div_a, div_b, div_sign SHALL stay stable from the div_valid_in cycle until div_valid_out is sampled (the divider samples operands late).
REQ-006 div_valid_in SHALL never be asserted outside the first WAIT cycle.
REQ-007 WAIT: div_valid_out=1 latches res_data (q for op 0/1, r for op 2/3), goes to DONE; res_valid=1 from the next cycle.
REQ-008 Divisor zero: res_dz=1 and res_data forced to 32'hFFFFFFFF for DIV/DIVU and to captured a for MOD/MODU, independent of div_q/div_r.
REQ-009 DONE: res_valid held with res_data stable until res_ready=1; that edge goes to IDLE.
REQ-010 busy SHALL be 1 in WAIT and DRAIN, 1 in DONE while res_ready=0, else 0.
REQ-011 flush in WAIT SHALL go to DRAIN; DRAIN waits for div_valid_out, discards it, then IDLE; no res_valid.
REQ-012 flush in DONE SHALL drop the result and go to IDLE; flush in IDLE SHALL block acceptance that cycle.
REQ-013 Watchdog counter SHALL clear on entering WAIT/DRAIN and count each cycle; at WDOG_CYCLES in WAIT go to DONE with res_timeout=1, res_data=0; in DRAIN go to IDLE.
REQ-014 res_dz and res_timeout SHALL be valid only while res_valid=1.
REQ-015 div_valid_out outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-016 rst low SHALL asynchronously force IDLE; busy, res_valid, res_dz, res_timeout, div_valid_in, div_sign=0; res_data, div_a, div_b=0; watchdog=0.
REQ-017 Reset mid-operation SHALL abandon the op; the bench resets divider and controller together.

Configuration
REQ-018 Macro DIV_RESULT_CACHE_EN defined: store last completed non-timeout {op sign, a, b, q, r}; an IDLE request with matching sign/a/b goes directly to DONE (res_valid next cycle), no div_valid_in; flush and reset invalidate the cache.
REQ-019 Macro undefined: no cache storage; every request goes through WAIT.

Verification
REQ-020 DIVU a=100 b=7, res_ready=1 -> one div_valid_in pulse, res_data=14, res_dz=0, busy low after.
REQ-021 MOD a=32'hFFFFFFF9 (-7) b=2 -> res_data=32'hFFFFFFFF (-1); DIV same operands -> 32'hFFFFFFFD (-3).
REQ-022 DIV a=5 b=0 -> res_dz=1, res_data=32'hFFFFFFFF; MODU a=5 b=0 -> res_data=5.
REQ-023 flush 2 cycles after accept -> DRAIN, divider pulse discarded, no res_valid, next request accepted only after IDLE.
REQ-024 div_valid_out held 0 -> res_timeout=1 after 15 WAIT cycles, res_data=0.
REQ-025 With DIV_RESULT_CACHE_EN: repeat DIVU 100/7 -> res_valid one cycle after accept, no div_valid_in, res_data=14.
